pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute FSM that steps, branches, jumps,
// traps and halts the PC, with a sticky flag for misaligned redirect targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        trap,
  input  logic        halt,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] candidate;
  logic        mis_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc_out     <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      pc_out     <= pc_next;
      misaligned <= mis_next;
    end
  end

  // Fetch handshake: imem_req is held for the whole FETCH state and the fetch
  // completes on the first rising edge that sees imem_ack=1; ack is ignored
  // in every other state, so a request can never be withdrawn before ack.
  always_comb begin
    state_next = state;
    pc_next    = pc_out;
    mis_next   = misaligned;
    candidate  = pc_out + 32'd4;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) state_next = EXEC;
      end
      EXEC: begin
        if (!stall) begin
          if (trap) begin
            pc_next    = TRAP_VECTOR;
            state_next = FETCH;
          end else if (halt) begin
            state_next = HALTED;
          end else begin
            if (jump_en) candidate = jump_target;
            else if (branch_taken) candidate = pc_out + branch_offset;
            state_next = FETCH;
            // A misaligned target is diverted to the trap handler and latched.
            if (candidate[1:0] != 2'b00) begin
              pc_next  = TRAP_VECTOR;
              mis_next = 1'b1;
            end else begin
              pc_next = candidate;
            end
          end
        end
      end
      HALTED: begin
        if (trap) begin
          pc_next    = TRAP_VECTOR;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALTED);
  assign dbg_state   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: hand sequences for reset, wait states, stall/halt
// and async reset, plus a table of redirect vectors applied from EXEC.
module tb_pc_sequencer;

  localparam int W = 36;
  localparam logic [2:0] O_I = 3'b000;
  localparam logic [2:0] O_F = 3'b100;
  localparam logic [2:0] O_E = 3'b010;
  localparam logic [2:0] O_H = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        trap;
  logic        halt;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        halted;
  logic        misaligned;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic cur_mis;

  typedef struct {
    logic [31:0] setup;
    logic        trap;
    logic        jump_en;
    logic [31:0] target;
    logic        br;
    logic [31:0] off;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_target(jump_target), .trap(trap), .halt(halt),
    .pc_out(pc_out), .instr_valid(instr_valid), .halted(halted),
    .misaligned(misaligned), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ex(input logic [2:0] o, input logic mis,
                                     input logic [31:0] pc);
    return {o, mis, pc};
  endfunction

  task automatic clear_ctrl();
    stall = 0; branch_taken = 0; branch_offset = 0; jump_en = 0;
    jump_target = 0; trap = 0; halt = 0;
  endtask

  // Scoreboard: pop one expectation and compare with the live outputs
  task automatic check_out(input string name);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {imem_req, instr_valid, halted, misaligned, pc_out};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h required an expectation (queue empty)", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got req/iv/hlt/mis/pc=%h required %h", name, got, e);
      end
    end
  endtask

  task automatic step_check(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    tick();
    check_out(name);
  endtask

  task automatic now_check(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    check_out(name);
  endtask

  // From EXEC: jump to v.setup, fetch, apply vector, fetch result
  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    clear_ctrl();
    jump_en = 1; jump_target = v.setup;
    step_check({n, "_setup_fetch"}, ex(O_F, cur_mis, v.setup));
    clear_ctrl();
    imem_ack = 1;
    step_check({n, "_setup_exec"}, ex(O_E, cur_mis, v.setup));
    trap = v.trap; jump_en = v.jump_en; jump_target = v.target;
    branch_taken = v.br; branch_offset = v.off;
    step_check({n, "_redirect"}, ex(O_F, v.exp_mis, v.exp_pc));
    cur_mis = v.exp_mis;
    clear_ctrl();
    step_check({n, "_exec"}, ex(O_E, cur_mis, v.exp_pc));
  endtask

  initial begin
    logic [31:0] r_off;
    vecs[0] = '{32'h10, 1, 1, 32'h200, 1, 32'h20, 32'h100, 0};
    vecs[1] = '{32'h10, 0, 1, 32'h200, 1, 32'h20, 32'h200, 0};
    vecs[2] = '{32'h10, 0, 0, 32'h0, 1, 32'h20, 32'h30, 0};
    vecs[3] = '{32'h10, 0, 0, 32'h0, 1, 32'hFFFF_FFF0, 32'h0, 0};
    vecs[4] = '{32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0};
    vecs[5] = '{32'h40, 0, 0, 32'h0, 0, 32'h0, 32'h44, 0};
    r_off = $urandom() & 32'hFFFF_FFFC;
    vecs[6] = '{32'h1000, 0, 0, 32'h0, 1, r_off, 32'h1000 + r_off, 0};
    vecs[7] = '{32'h10, 0, 1, 32'h202, 0, 32'h0, 32'h100, 1};
    vecs[8] = '{32'h40, 0, 0, 32'h0, 1, 32'h1, 32'h100, 1};
    vecs[9] = '{32'h10, 0, 1, 32'h300, 0, 32'h0, 32'h300, 1};

    // Reset
    reset = 0; imem_ack = 0; cur_mis = 0;
    clear_ctrl();
    tick(); tick();
    now_check("reset_state", ex(O_I, 0, 32'h0));
    reset = 1;

    // Sequential fetch and wait states
    step_check("idle_to_fetch", ex(O_F, 0, 32'h0));
    imem_ack = 1;
    step_check("exec_pc0", ex(O_E, 0, 32'h0));
    step_check("fetch_pc4", ex(O_F, 0, 32'h4));
    imem_ack = 0;
    for (int i = 0; i < 3; i++) step_check($sformatf("wait%0d", i), ex(O_F, 0, 32'h4));
    imem_ack = 1;
    step_check("exec_pc4", ex(O_E, 0, 32'h4));
    step_check("fetch_pc8", ex(O_F, 0, 32'h8));
    step_check("exec_pc8", ex(O_E, 0, 32'h8));

    // Stall dominates trap, then halt and trap out of HALTED
    stall = 1; trap = 1;
    for (int i = 0; i < 4; i++) step_check($sformatf("stall%0d", i), ex(O_E, 0, 32'h8));
    clear_ctrl(); halt = 1;
    step_check("halt", ex(O_H, 0, 32'h8));
    clear_ctrl(); jump_en = 1; jump_target = 32'h200; branch_taken = 1;
    step_check("halted_ignores", ex(O_H, 0, 32'h8));
    clear_ctrl(); trap = 1;
    step_check("halted_trap", ex(O_F, 0, 32'h100));
    clear_ctrl();
    step_check("exec_trap_vec", ex(O_E, 0, 32'h100));

    // Redirect table
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Async reset mid-EXEC with a pending jump
    jump_en = 1; jump_target = 32'h200;
    #2;
    reset = 0;
    #1;
    now_check("async_reset", ex(O_I, 0, 32'h0));
    tick();
    now_check("reset_hold", ex(O_I, 0, 32'h0));
    reset = 1;
    step_check("post_reset_fetch", ex(O_F, 0, 32'h0));
    clear_ctrl();
    step_check("post_reset_exec", ex(O_E, 0, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
